// File: rtl/qspi_arbiter_if.sv
// Bundles the fetch port, the data port, the QSPI request/completion bus and the status signals.
// Latency: none; this only carries signals.
// Backpressure: requesters hold their req level until the matching one-cycle ack arrives.
interface qspi_arbiter_if;
    // Instruction fetch port
    logic        i_req;
    logic [31:0] i_adr;
    logic        i_ack;
    logic [31:0] i_rdata;
    // Data load/store port
    logic        d_req;
    logic        d_we;
    logic        d_w;
    logic        d_hw;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    // QSPI interface side
    logic        q_read_req;
    logic        q_write_req;
    logic        q_w;
    logic        q_hw;
    logic [31:0] q_adr;
    logic [31:0] q_wdata;
    logic        q_read_valid;
    logic [31:0] q_read_data;
    logic        q_write_finish;
    // Status
    logic        busy;
    logic        tmo_err;
    logic        tmo_clr;

    // Arbiter side
    modport slave (
        input  i_req, i_adr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_w, d_hw, d_adr, d_wdata,
        output d_ack, d_rdata,
        output q_read_req, q_write_req, q_w, q_hw, q_adr, q_wdata,
        input  q_read_valid, q_read_data, q_write_finish,
        output busy, tmo_err,
        input  tmo_clr
    );

    // Requesters plus QSPI interface (environment side)
    modport master (
        output i_req, i_adr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_w, d_hw, d_adr, d_wdata,
        input  d_ack, d_rdata,
        input  q_read_req, q_write_req, q_w, q_hw, q_adr, q_wdata,
        output q_read_valid, q_read_data, q_write_finish,
        input  busy, tmo_err,
        output tmo_clr
    );
endinterface

// File: rtl/qspi_arbiter.sv
// Shares one QSPI interface between a fetch port (word reads) and a data port (read/write).
// Latency: req in IDLE cycle N -> q_*_req in N+1; completion strobe in cycle M -> ack in M+1.
// Backpressure: requesters hold req until ack; one transaction in flight, watchdog bounds WAIT.
module qspi_arbiter #(
    parameter bit          PRIO_DATA   = 1'b0,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          rst,
    qspi_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        DRAIN
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic        last_d;     // 1 = last grant went to the data port
    logic        gnt_d;      // port owning the current transaction
    logic        lat_we;
    logic        lat_w;
    logic        lat_hw;
    logic [31:0] lat_adr;
    logic [31:0] lat_wdata;
    logic [15:0] tmo_cnt;

    logic        i_ack_r;
    logic        d_ack_r;
    logic [31:0] i_rdata_r;
    logic [31:0] d_rdata_r;
    logic        q_rd_r;
    logic        q_wr_r;
    logic        busy_r;
    logic        tmo_err_r;

    logic        pick_d;
    logic        done;

    // Data wins when it is the only requester, when it has fixed priority,
    // or when round-robin says it is its turn (fetch had the last grant).
    assign pick_d = bus.d_req && (!bus.i_req || PRIO_DATA || !last_d);

    // Only the completion strobe matching the granted direction counts.
    assign done = lat_we ? bus.q_write_finish : bus.q_read_valid;

    // Arbitration, transaction sequencing, watchdog and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            gnt_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_w     <= 1'b0;
            lat_hw    <= 1'b0;
            lat_adr   <= 32'h0;
            lat_wdata <= 32'h0;
            tmo_cnt   <= 16'h0;
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            i_rdata_r <= 32'h0;
            d_rdata_r <= 32'h0;
            q_rd_r    <= 1'b0;
            q_wr_r    <= 1'b0;
            busy_r    <= 1'b0;
            tmo_err_r <= 1'b0;
        end else begin
            i_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            q_rd_r  <= 1'b0;
            q_wr_r  <= 1'b0;
            // A timeout set further down overrides this clear.
            if (bus.tmo_clr) begin
                tmo_err_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        gnt_d  <= pick_d;
                        last_d <= pick_d;
                        busy_r <= 1'b1;
                        state  <= ISSUE;
                        if (pick_d) begin
                            lat_we    <= bus.d_we;
                            lat_w     <= bus.d_w;
                            lat_hw    <= bus.d_hw;
                            lat_adr   <= bus.d_adr;
                            lat_wdata <= bus.d_wdata;
                            q_rd_r    <= !bus.d_we;
                            q_wr_r    <= bus.d_we;
                        end else begin
                            lat_we  <= 1'b0;
                            lat_w   <= 1'b1;
                            lat_hw  <= 1'b0;
                            lat_adr <= bus.i_adr;
                            q_rd_r  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt <= 16'h0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        if (!lat_we) begin
                            if (gnt_d) begin
                                d_rdata_r <= bus.q_read_data;
                            end else begin
                                i_rdata_r <= bus.q_read_data;
                            end
                        end
                        i_ack_r <= !gnt_d;
                        d_ack_r <= gnt_d;
                        state   <= ACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abandon the transaction but keep the QSPI side
                        // owned until its late strobe shows up. A timed-out
                        // write leaves d_rdata alone, like any other write.
                        tmo_err_r <= 1'b1;
                        if (!lat_we) begin
                            if (gnt_d) begin
                                d_rdata_r <= 32'h0;
                            end else begin
                                i_rdata_r <= 32'h0;
                            end
                        end
                        i_ack_r <= !gnt_d;
                        d_ack_r <= gnt_d;
                        state   <= DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'h1;
                    end
                end
                ACK: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                DRAIN: begin
                    if (bus.q_read_valid || bus.q_write_finish) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack       = i_ack_r;
    assign bus.i_rdata     = i_rdata_r;
    assign bus.d_ack       = d_ack_r;
    assign bus.d_rdata     = d_rdata_r;
    assign bus.q_read_req  = q_rd_r;
    assign bus.q_write_req = q_wr_r;
    assign bus.q_w         = lat_w;
    assign bus.q_hw        = lat_hw;
    assign bus.q_adr       = lat_adr;
    assign bus.q_wdata     = lat_wdata;
    assign bus.busy        = busy_r;
    assign bus.tmo_err     = tmo_err_r;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Bench for qspi_arbiter: round-robin/timeout instance plus a data-priority instance.
// Latency: QSPI responder model answers a configurable number of cycles after each request pulse.
// Backpressure: requesters hold req until ack; scoreboard holds expected ack order and data.
module tb_qspi_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qspi_arbiter_if b0();
    qspi_arbiter_if b1();

    qspi_arbiter #(.PRIO_DATA(1'b0), .TIMEOUT_CYC(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    qspi_arbiter #(.PRIO_DATA(1'b1), .TIMEOUT_CYC(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        bit          port_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rsp_dly = 8;
    bit          rsp_en = 1'b1;
    bit          kick0 = 1'b0;
    logic [31:0] d_model = 32'h0;
    int          cnt_i;
    int          cnt_d;

    function automatic logic [31:0] rd_fn(input logic [31:0] adr);
        return (adr == 32'h1000) ? 32'h1234_5678 : (adr ^ 32'h5A5A_0000);
    endfunction

    // QSPI responder for the round-robin instance
    initial begin : resp0
        int cnt;
        bit wr;
        cnt = 0;
        wr = 1'b0;
        b0.q_read_valid = 1'b0;
        b0.q_write_finish = 1'b0;
        b0.q_read_data = 32'h0;
        forever begin
            @(negedge clk);
            b0.q_read_valid = 1'b0;
            b0.q_write_finish = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (kick0) begin
                kick0 = 1'b0;
                b0.q_read_valid = 1'b1;
                b0.q_read_data = rd_fn(b0.q_adr);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (wr) b0.q_write_finish = 1'b1;
                    else begin
                        b0.q_read_valid = 1'b1;
                        b0.q_read_data = rd_fn(b0.q_adr);
                    end
                end
            end else if (rsp_en && (b0.q_read_req || b0.q_write_req)) begin
                wr = b0.q_write_req;
                cnt = rsp_dly;
            end
        end
    end

    // QSPI responder for the data-priority instance
    initial begin : resp1
        int cnt;
        bit wr;
        cnt = 0;
        wr = 1'b0;
        b1.q_read_valid = 1'b0;
        b1.q_write_finish = 1'b0;
        b1.q_read_data = 32'h0;
        forever begin
            @(negedge clk);
            b1.q_read_valid = 1'b0;
            b1.q_write_finish = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (wr) b1.q_write_finish = 1'b1;
                    else begin
                        b1.q_read_valid = 1'b1;
                        b1.q_read_data = rd_fn(b1.q_adr);
                    end
                end
            end else if (b1.q_read_req || b1.q_write_req) begin
                wr = b1.q_write_req;
                cnt = rsp_dly;
            end
        end
    end

    task automatic init_inputs();
        rst = 1'b1;
        b0.i_req = 1'b0; b0.i_adr = 32'h0; b0.d_req = 1'b0; b0.d_we = 1'b0;
        b0.d_w = 1'b0; b0.d_hw = 1'b0; b0.d_adr = 32'h0; b0.d_wdata = 32'h0; b0.tmo_clr = 1'b0;
        b1.i_req = 1'b0; b1.i_adr = 32'h0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b1.d_w = 1'b0; b1.d_hw = 1'b0; b1.d_adr = 32'h0; b1.d_wdata = 32'h0; b1.tmo_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ctl = {b0.busy, b0.i_ack, b0.d_ack, b0.q_read_req, b0.q_write_req, b0.tmo_err, b0.q_w, b0.q_hw};
        n_cmp++;
        if (ctl !== 8'h0) begin n_bad++; $display("FAIL reset_ctl: got %b expected 00000000", ctl); end
        n_cmp++;
        if ({b0.i_rdata, b0.d_rdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h/%h expected 0/0", b0.i_rdata, b0.d_rdata);
        end
        n_cmp++;
        if ({b0.q_adr, b0.q_wdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_qbus: got %h/%h expected 0/0", b0.q_adr, b0.q_wdata);
        end
        n_cmp++;
        if ({b1.busy, b1.i_ack, b1.d_ack, b1.tmo_err} !== 4'h0) begin
            n_bad++; $display("FAIL reset_dut1: got %b expected 0000", {b1.busy, b1.i_ack, b1.d_ack, b1.tmo_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Fetch read with latency check; used both standalone and after a reset.
    task automatic test_i_only(input string tag);
        exp_t e;
        int npulse = 0, req_k = -1, ack_k = -1;
        bit attr_ok = 1'b1;
        sb.push_back('{1'b0, 32'h1234_5678});
        b0.i_adr = 32'h1000;
        b0.i_req = 1'b1;
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            @(negedge clk);
            if (b0.q_read_req) begin
                npulse++;
                if (req_k < 0) req_k = k;
                if (b0.q_adr !== 32'h1000 || b0.q_w !== 1'b1 || b0.q_hw !== 1'b0 || b0.q_write_req !== 1'b0)
                    attr_ok = 1'b0;
            end
            if (b0.i_ack) begin
                ack_k = k;
                b0.i_req = 1'b0;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL %s_sb: unexpected i_ack", tag); end
                else begin
                    e = sb.pop_front();
                    if (e.port_d !== 1'b0 || b0.i_rdata !== e.rdata || b0.d_ack !== 1'b0) begin
                        n_bad++; $display("FAIL %s_data: got %h expected %h", tag, b0.i_rdata, e.rdata);
                    end
                end
            end
        end
        n_cmp++;
        if (req_k !== 1 || npulse !== 1 || !attr_ok) begin
            n_bad++; $display("FAIL %s_issue: got k=%0d pulses=%0d attr=%0d expected k=1 pulses=1 attr=1", tag, req_k, npulse, attr_ok);
        end
        n_cmp++;
        if (ack_k !== 10) begin n_bad++; $display("FAIL %s_latency: got ack at %0d expected 10", tag, ack_k); end
        @(negedge clk);
        n_cmp++;
        if (b0.i_ack !== 1'b0 || b0.i_rdata !== 32'h1234_5678 || b0.busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_after: got ack=%b rdata=%h busy=%b expected 0 12345678 0", tag, b0.i_ack, b0.i_rdata, b0.busy);
        end
    endtask

    task automatic test_d_write();
        exp_t e;
        int npulse = 0, ack_k = -1;
        bit attr_ok = 1'b1, hold_ok = 1'b1;
        rsp_dly = 3;
        sb.push_back('{1'b1, d_model});
        b0.d_we = 1'b1; b0.d_w = 1'b0; b0.d_hw = 1'b0; b0.d_adr = 32'h20; b0.d_wdata = 32'hAB;
        b0.d_req = 1'b1;
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            @(negedge clk);
            if (npulse > 0 && b0.q_wdata !== 32'hAB) hold_ok = 1'b0;
            if (b0.q_write_req) begin
                npulse++;
                if (b0.q_w !== 1'b0 || b0.q_hw !== 1'b0 || b0.q_read_req !== 1'b0 ||
                    b0.q_adr !== 32'h20 || b0.q_wdata !== 32'hAB || k != 1)
                    attr_ok = 1'b0;
                b0.d_wdata = 32'hFFFF_FFFF;
            end
            if (b0.d_ack) begin
                ack_k = k;
                b0.d_req = 1'b0;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL dwr_sb: unexpected d_ack"); end
                else begin
                    e = sb.pop_front();
                    if (e.port_d !== 1'b1 || b0.d_rdata !== e.rdata || b0.i_ack !== 1'b0) begin
                        n_bad++; $display("FAIL dwr_rdata: got %h expected %h", b0.d_rdata, e.rdata);
                    end
                end
            end
        end
        n_cmp++;
        if (npulse !== 1 || !attr_ok) begin
            n_bad++; $display("FAIL dwr_issue: got pulses=%0d attr=%0d expected 1 1", npulse, attr_ok);
        end
        n_cmp++;
        if (!hold_ok) begin n_bad++; $display("FAIL dwr_wdata_hold: q_wdata left %h", 32'hAB); end
        n_cmp++;
        if (ack_k !== 5) begin n_bad++; $display("FAIL dwr_latency: got ack at %0d expected 5", ack_k); end
        @(negedge clk);
    endtask

    task automatic test_d_read();
        logic [31:0] adrs [2];
        logic        ws [2];
        logic        hws [2];
        adrs[0] = 32'h42; ws[0] = 1'b0; hws[0] = 1'b1;
        adrs[1] = 32'h84; ws[1] = 1'b1; hws[1] = 1'b0;
        rsp_dly = 2;
        for (int t = 0; t < 2; t++) begin
            exp_t e;
            int ack_k = -1;
            bit attr_ok = 1'b0;
            d_model = rd_fn(adrs[t]);
            sb.push_back('{1'b1, d_model});
            b0.d_we = 1'b0; b0.d_w = ws[t]; b0.d_hw = hws[t]; b0.d_adr = adrs[t];
            b0.d_req = 1'b1;
            for (int k = 1; k <= 40 && ack_k < 0; k++) begin
                @(negedge clk);
                if (b0.q_read_req && b0.q_write_req === 1'b0 && b0.q_w === ws[t] &&
                    b0.q_hw === hws[t] && b0.q_adr === adrs[t])
                    attr_ok = 1'b1;
                if (b0.d_ack) begin
                    ack_k = k;
                    b0.d_req = 1'b0;
                    n_cmp++;
                    if (sb.size() == 0) begin n_bad++; $display("FAIL drd_sb: unexpected d_ack"); end
                    else begin
                        e = sb.pop_front();
                        if (e.port_d !== 1'b1 || b0.d_rdata !== e.rdata) begin
                            n_bad++; $display("FAIL drd_data%0d: got %h expected %h", t, b0.d_rdata, e.rdata);
                        end
                    end
                end
            end
            n_cmp++;
            if (!attr_ok || ack_k < 0) begin
                n_bad++; $display("FAIL drd_issue%0d: got attr=%0d ack_k=%0d expected attr=1 and an ack", t, attr_ok, ack_k);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (b0.i_rdata !== 32'h1234_5678) begin
            n_bad++; $display("FAIL drd_i_untouched: got %h expected 12345678", b0.i_rdata);
        end
    endtask

    task automatic test_contention_rr();
        rsp_dly = 4;
        sb.push_back('{1'b0, rd_fn(32'h3000)});
        sb.push_back('{1'b1, rd_fn(32'h4000)});
        sb.push_back('{1'b0, rd_fn(32'h3000)});
        sb.push_back('{1'b1, rd_fn(32'h4000)});
        cnt_i = 0; cnt_d = 0;
        fork
            begin : br_i
                exp_t e;
                b0.i_adr = 32'h3000; b0.i_req = 1'b1;
                for (int c = 0; c < 300 && cnt_i < 2; c++) begin
                    @(negedge clk);
                    if (b0.i_ack) begin
                        cnt_i++;
                        if (cnt_i == 2) b0.i_req = 1'b0;
                        n_cmp++;
                        e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 32'hX};
                        if (e.port_d !== 1'b0 || b0.i_rdata !== e.rdata) begin
                            n_bad++; $display("FAIL rr_order_i%0d: got port I data %h expected port %0d data %h", cnt_i, b0.i_rdata, e.port_d, e.rdata);
                        end
                    end
                end
            end
            begin : br_d
                exp_t e;
                b0.d_we = 1'b0; b0.d_w = 1'b1; b0.d_hw = 1'b0; b0.d_adr = 32'h4000; b0.d_req = 1'b1;
                for (int c = 0; c < 300 && cnt_d < 2; c++) begin
                    @(negedge clk);
                    if (b0.d_ack) begin
                        cnt_d++;
                        if (cnt_d == 2) b0.d_req = 1'b0;
                        n_cmp++;
                        e = (sb.size() > 0) ? sb.pop_front() : '{1'b0, 32'hX};
                        if (e.port_d !== 1'b1 || b0.d_rdata !== e.rdata) begin
                            n_bad++; $display("FAIL rr_order_d%0d: got port D data %h expected port %0d data %h", cnt_d, b0.d_rdata, e.port_d, e.rdata);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (cnt_i != 2 || cnt_d != 2 || sb.size() != 0) begin
            n_bad++; $display("FAIL rr_done: got I=%0d D=%0d left=%0d expected 2 2 0", cnt_i, cnt_d, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_contention_prio();
        rsp_dly = 4;
        sb.push_back('{1'b1, rd_fn(32'h4400)});
        sb.push_back('{1'b1, rd_fn(32'h4400)});
        sb.push_back('{1'b1, rd_fn(32'h4400)});
        sb.push_back('{1'b0, rd_fn(32'h3300)});
        cnt_i = 0; cnt_d = 0;
        fork
            begin : br_i
                exp_t e;
                b1.i_adr = 32'h3300; b1.i_req = 1'b1;
                for (int c = 0; c < 400 && cnt_i < 1; c++) begin
                    @(negedge clk);
                    if (b1.i_ack) begin
                        cnt_i++;
                        b1.i_req = 1'b0;
                        n_cmp++;
                        e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 32'hX};
                        if (e.port_d !== 1'b0 || b1.i_rdata !== e.rdata) begin
                            n_bad++; $display("FAIL prio_order_i: got port I data %h expected port %0d data %h", b1.i_rdata, e.port_d, e.rdata);
                        end
                    end
                end
            end
            begin : br_d
                exp_t e;
                b1.d_we = 1'b0; b1.d_w = 1'b1; b1.d_hw = 1'b0; b1.d_adr = 32'h4400; b1.d_req = 1'b1;
                for (int c = 0; c < 400 && cnt_d < 3; c++) begin
                    @(negedge clk);
                    if (b1.d_ack) begin
                        cnt_d++;
                        if (cnt_d == 3) b1.d_req = 1'b0;
                        n_cmp++;
                        e = (sb.size() > 0) ? sb.pop_front() : '{1'b0, 32'hX};
                        if (e.port_d !== 1'b1 || b1.d_rdata !== e.rdata) begin
                            n_bad++; $display("FAIL prio_order_d%0d: got port D data %h expected port %0d data %h", cnt_d, b1.d_rdata, e.port_d, e.rdata);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (cnt_i != 1 || cnt_d != 3 || sb.size() != 0) begin
            n_bad++; $display("FAIL prio_done: got I=%0d D=%0d left=%0d expected 1 3 0", cnt_i, cnt_d, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        int ack_k = -1, idle_k = -1;
        rsp_en = 1'b0;
        sb.push_back('{1'b0, 32'h0});
        b0.i_adr = 32'h5000; b0.i_req = 1'b1;
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            @(negedge clk);
            if (b0.i_ack) begin
                ack_k = k;
                b0.i_req = 1'b0;
                n_cmp++;
                e = (sb.size() > 0) ? sb.pop_front() : '{1'b1, 32'hX};
                if (e.port_d !== 1'b0 || b0.i_rdata !== e.rdata || b0.tmo_err !== 1'b1) begin
                    n_bad++; $display("FAIL tmo_ack: got rdata=%h err=%b expected %h 1", b0.i_rdata, b0.tmo_err, e.rdata);
                end
            end
        end
        n_cmp++;
        if (ack_k !== 18) begin n_bad++; $display("FAIL tmo_latency: got ack at %0d expected 18", ack_k); end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (b0.busy !== 1'b1 || b0.i_ack !== 1'b0 || b0.tmo_err !== 1'b1) begin
            n_bad++; $display("FAIL tmo_drain: got busy=%b ack=%b err=%b expected 1 0 1", b0.busy, b0.i_ack, b0.tmo_err);
        end
        kick0 = 1'b1;
        for (int k = 1; k <= 6 && idle_k < 0; k++) begin
            @(negedge clk);
            if (b0.busy === 1'b0) idle_k = k;
        end
        n_cmp++;
        if (idle_k < 0 || b0.i_rdata !== 32'h0 || b0.tmo_err !== 1'b1 || b0.i_ack !== 1'b0) begin
            n_bad++; $display("FAIL tmo_late: got idle_k=%0d rdata=%h err=%b expected idle, 0, 1", idle_k, b0.i_rdata, b0.tmo_err);
        end
        b0.tmo_clr = 1'b1;
        @(negedge clk);
        b0.tmo_clr = 1'b0;
        n_cmp++;
        if (b0.tmo_err !== 1'b0) begin n_bad++; $display("FAIL tmo_clr: got %b expected 0", b0.tmo_err); end
        rsp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        int nack = 0;
        bit seen = 1'b0;
        rsp_dly = 20;
        b0.i_adr = 32'h6000; b0.i_req = 1'b1;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            if (b0.q_read_req) seen = 1'b1;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (!seen || b0.busy !== 1'b1) begin
            n_bad++; $display("FAIL rstw_pre: got req_seen=%0d busy=%b expected 1 1", seen, b0.busy);
        end
        rst = 1'b1;
        b0.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({b0.busy, b0.i_ack, b0.d_ack, b0.q_read_req, b0.q_write_req, b0.tmo_err} !== 6'h0 ||
            b0.q_adr !== 32'h0 || b0.d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rstw_clear: got busy=%b q_adr=%h d_rdata=%h expected 0 0 0", b0.busy, b0.q_adr, b0.d_rdata);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (b0.i_ack || b0.d_ack || b0.busy) nack++;
        end
        n_cmp++;
        if (nack != 0) begin n_bad++; $display("FAIL rstw_quiet: got %0d active cycles expected 0", nack); end
        rsp_dly = 8;
        test_i_only("rstw_txn");
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_i_only("i_only");
        test_d_write();
        test_d_read();
        test_contention_rr();
        test_contention_prio();
        test_timeout();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
